// File: rtl/cycle_monitor_if.sv
// rtl/cycle_monitor_if.sv - handshake/observation bundle between a cycle_monitor and its pipeline
interface cycle_monitor_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 1
);
    logic [NCH-1:0]   halt;
    logic             retire;
    logic             stall;
    logic [WIDTH-1:0] cycles;
    logic [WIDTH-1:0] retired;
    logic [WIDTH-1:0] stalls;
    logic [NCH-1:0]   halt_src;
    logic [1:0]       state;
    logic             done;
    logic             timeout;

    modport master (
        output halt, retire, stall,
        input  cycles, retired, stalls, halt_src, state, done, timeout
    );

    modport slave (
        input  halt, retire, stall,
        output cycles, retired, stalls, halt_src, state, done, timeout
    );
endinterface

// File: rtl/cycle_monitor.sv
// rtl/cycle_monitor.sv - run/drain/done cycle, retire and stall counter with halt capture and timeout
module cycle_monitor #(
    parameter int WIDTH      = 16,
    parameter int MAX_CYCLES = 850,
    parameter int NCH        = 1,
    parameter int DRAIN      = 4
) (
    input logic            clk,
    input logic            reset,
    cycle_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] LIMIT      = WIDTH'(MAX_CYCLES);
    localparam logic [7:0]       DRAIN_LAST = 8'((DRAIN > 0) ? DRAIN - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cycles_q, cycles_d;
    logic [WIDTH-1:0] retired_q, retired_d;
    logic [WIDTH-1:0] stalls_q, stalls_d;
    logic [NCH-1:0]   halt_src_q, halt_src_d;
    logic [7:0]       drain_cnt_q, drain_cnt_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             count_en;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + WIDTH'(1) : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        halt_src_d  = halt_src_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        count_en    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A halt on the limit cycle wins, and that edge still counts as a RUN edge.
                if (|mon.halt) begin
                    count_en    = 1'b1;
                    halt_src_d  = mon.halt;
                    drain_cnt_d = 8'd0;
                    if (DRAIN > 0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (cycles_q == LIMIT) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    count_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                count_en = 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        cycles_d  = count_en ? sat_inc(cycles_q, 1'b1) : cycles_q;
        retired_d = count_en ? sat_inc(retired_q, mon.retire) : retired_q;
        stalls_d  = count_en ? sat_inc(stalls_q, mon.stall) : stalls_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cycles_q    <= '0;
            retired_q   <= '0;
            stalls_q    <= '0;
            halt_src_q  <= '0;
            drain_cnt_q <= 8'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            retired_q   <= retired_d;
            stalls_q    <= stalls_d;
            halt_src_q  <= halt_src_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mon.cycles   = cycles_q;
    assign mon.retired  = retired_q;
    assign mon.stalls   = stalls_q;
    assign mon.halt_src = halt_src_q;
    assign mon.state    = state_q;
    assign mon.done     = done_q;
    assign mon.timeout  = timeout_q;
endmodule

// File: tb/tb_cycle_monitor.sv
// tb/tb_cycle_monitor.sv - randomized and directed self-checking bench for cycle_monitor
module tb_cycle_monitor;
    logic       clk;
    logic       reset;
    logic [2:0] halt;
    logic       retire;
    logic       stall;

    int n_checks = 0;
    int n_err    = 0;

    cycle_monitor_if #(.WIDTH(16), .NCH(3)) if0 ();
    cycle_monitor_if #(.WIDTH(4),  .NCH(3)) if1 ();
    cycle_monitor_if #(.WIDTH(8),  .NCH(3)) if2 ();

    assign if0.halt = halt;  assign if0.retire = retire;  assign if0.stall = stall;
    assign if1.halt = halt;  assign if1.retire = retire;  assign if1.stall = stall;
    assign if2.halt = halt;  assign if2.retire = retire;  assign if2.stall = stall;

    cycle_monitor #(.WIDTH(16), .MAX_CYCLES(850), .NCH(3), .DRAIN(4)) u0 (.clk(clk), .reset(reset), .mon(if0));
    cycle_monitor #(.WIDTH(4),  .MAX_CYCLES(15),  .NCH(3), .DRAIN(4)) u1 (.clk(clk), .reset(reset), .mon(if1));
    cycle_monitor #(.WIDTH(8),  .MAX_CYCLES(20),  .NCH(3), .DRAIN(0)) u2 (.clk(clk), .reset(reset), .mon(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit     draining;
        bit     done;
        bit     to;
        int     left;
        longint cyc;
        longint ret;
        longint stl;
        int     src;
    } mdl_t;

    mdl_t m0, m1, m2;
    bit   valid = 1'b0;

    function automatic longint clip(input longint v, input longint cap);
        return (v > cap) ? cap : v;
    endfunction

    function automatic mdl_t step(input mdl_t m, input longint maxc, input int drain, input longint cap,
                                  input bit rst, input int h, input bit r, input bit s);
        mdl_t n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (m.done) return n;
        if (!m.draining && h == 0 && m.cyc == maxc) begin
            n.done = 1;
            n.to   = 1;
            return n;
        end
        n.cyc = clip(m.cyc + 1, cap);
        n.ret = clip(m.ret + longint'(r), cap);
        n.stl = clip(m.stl + longint'(s), cap);
        if (m.draining) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.draining = 0;
                n.done     = 1;
            end
        end else if (h != 0) begin
            n.src = h;
            if (drain == 0) n.done = 1;
            else begin
                n.draining = 1;
                n.left     = drain;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m0 <= step(m0, 850, 4, 65535, reset, int'(halt), retire, stall);
        m1 <= step(m1, 15,  4, 15,    reset, int'(halt), retire, stall);
        m2 <= step(m2, 20,  0, 255,   reset, int'(halt), retire, stall);
        if (reset) valid <= 1'b1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input longint cyc, input longint ret,
                       input longint stl, input longint src, input longint st, input longint dn,
                       input longint to);
        check({tag, ".cycles"},   cyc, m.cyc);
        check({tag, ".retired"},  ret, m.ret);
        check({tag, ".stalls"},   stl, m.stl);
        check({tag, ".halt_src"}, src, longint'(m.src));
        check({tag, ".state"},    st,  m.done ? 2 : (m.draining ? 1 : 0));
        check({tag, ".done"},     dn,  longint'(m.done));
        check({tag, ".timeout"},  to,  longint'(m.to));
    endtask

    always @(negedge clk) begin
        if (valid) begin
            cmp("u0", m0, longint'(if0.cycles), longint'(if0.retired), longint'(if0.stalls),
                longint'(if0.halt_src), longint'(if0.state), longint'(if0.done), longint'(if0.timeout));
            cmp("u1", m1, longint'(if1.cycles), longint'(if1.retired), longint'(if1.stalls),
                longint'(if1.halt_src), longint'(if1.state), longint'(if1.done), longint'(if1.timeout));
            cmp("u2", m2, longint'(if2.cycles), longint'(if2.retired), longint'(if2.stalls),
                longint'(if2.halt_src), longint'(if2.state), longint'(if2.done), longint'(if2.timeout));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        halt   = 3'b000;
        retire = 1'b0;
        stall  = 1'b0;
        @(negedge clk);

        // reset state and free-running timeout at the default limit
        do_reset();
        check("rst.cycles",   longint'(if0.cycles), 0);
        check("rst.state",    longint'(if0.state), 0);
        check("rst.done",     longint'(if0.done), 0);
        check("rst.halt_src", longint'(if0.halt_src), 0);
        retire = 1'b1;
        tick(850);
        check("lim.cycles850",  longint'(if0.cycles), 850);
        check("lim.run",        longint'(if0.state), 0);
        tick();
        check("lim.state_done", longint'(if0.state), 2);
        check("lim.timeout",    longint'(if0.timeout), 1);
        check("lim.cycles",     longint'(if0.cycles), 850);
        check("lim.retired",    longint'(if0.retired), 850);
        check("lim.u1_timeout", longint'(if1.timeout), 1);
        check("lim.u1_cycles",  longint'(if1.cycles), 15);

        // halt at cycles=10, later halt change ignored during drain
        retire = 1'b0;
        do_reset();
        tick(10);
        halt = 3'b100;
        tick();
        check("h.state_drain", longint'(if0.state), 1);
        check("h.src",         longint'(if0.halt_src), 4);
        check("h.u2_done",     longint'(if2.done), 1);
        check("h.u2_cycles",   longint'(if2.cycles), 11);
        halt = 3'b011;
        tick(3);
        check("h.not_done_yet", longint'(if0.done), 0);
        tick();
        check("h.done",    longint'(if0.done), 1);
        check("h.cycles",  longint'(if0.cycles), 15);
        check("h.timeout", longint'(if0.timeout), 0);
        check("h.src_held", longint'(if0.halt_src), 4);
        halt = 3'b000;

        // narrow counters saturate instead of wrapping
        do_reset();
        stall = 1'b1;
        tick(14);
        halt = 3'b001;
        tick();
        halt = 3'b000;
        tick(4);
        check("sat.stalls", longint'(if1.stalls), 15);
        check("sat.cycles", longint'(if1.cycles), 15);
        check("sat.done",   longint'(if1.done), 1);
        stall = 1'b0;

        // halt on the limit cycle beats the timeout
        do_reset();
        tick(15);
        halt = 3'b010;
        tick();
        halt = 3'b000;
        check("hl.state_drain", longint'(if1.state), 1);
        tick(4);
        check("hl.done",    longint'(if1.done), 1);
        check("hl.timeout", longint'(if1.timeout), 0);

        // reset in the middle of drain
        do_reset();
        tick(3);
        halt = 3'b001;
        tick();
        halt = 3'b000;
        tick(2);
        do_reset();
        check("md.cycles",   longint'(if0.cycles), 0);
        check("md.state",    longint'(if0.state), 0);
        check("md.halt_src", longint'(if0.halt_src), 0);
        tick();
        check("md.restart",  longint'(if0.cycles), 1);

        // randomized traffic with occasional halts and resets
        for (int round = 0; round < 8; round++) begin
            int len;
            int rate;
            do_reset();
            len  = $urandom_range(50, 1200);
            rate = (round % 2 == 0) ? 150 : 2000;
            for (int c = 0; c < len; c++) begin
                retire = 1'($urandom_range(0, 1));
                stall  = 1'($urandom_range(0, 1));
                halt   = ($urandom_range(0, rate - 1) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                reset  = ($urandom_range(0, 499) == 0);
                tick();
            end
            reset = 1'b0;
            halt  = 3'b000;
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
